// File: rtl/axi_lite_arbiter.sv
// Round-robin N-to-1 AXI4-Lite arbiter with one transaction in flight.
// The granted master's channels are passed through combinationally to the slave port.
module axi_lite_arbiter #(
  parameter int NUM_MASTERS = 2,
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int STRB_WIDTH  = DATA_WIDTH/8,
  parameter int IDW         = $clog2(NUM_MASTERS)
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_araddr,
  input  logic [NUM_MASTERS-1:0]            m_arvalid,
  output logic [NUM_MASTERS-1:0]            m_arready,
  output logic [DATA_WIDTH-1:0]             m_rdata,
  output logic [1:0]                        m_rresp,
  output logic [NUM_MASTERS-1:0]            m_rvalid,
  input  logic [NUM_MASTERS-1:0]            m_rready,
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_awaddr,
  input  logic [NUM_MASTERS-1:0]            m_awvalid,
  output logic [NUM_MASTERS-1:0]            m_awready,
  input  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_wdata,
  input  logic [NUM_MASTERS*STRB_WIDTH-1:0] m_wstrb,
  input  logic [NUM_MASTERS-1:0]            m_wvalid,
  output logic [NUM_MASTERS-1:0]            m_wready,
  output logic [1:0]                        m_bresp,
  output logic [NUM_MASTERS-1:0]            m_bvalid,
  input  logic [NUM_MASTERS-1:0]            m_bready,
  output logic [ADDR_WIDTH-1:0]             s_araddr,
  output logic                              s_arvalid,
  input  logic                              s_arready,
  input  logic [DATA_WIDTH-1:0]             s_rdata,
  input  logic [1:0]                        s_rresp,
  input  logic                              s_rvalid,
  output logic                              s_rready,
  output logic [ADDR_WIDTH-1:0]             s_awaddr,
  output logic                              s_awvalid,
  input  logic                              s_awready,
  output logic [DATA_WIDTH-1:0]             s_wdata,
  output logic [STRB_WIDTH-1:0]             s_wstrb,
  output logic                              s_wvalid,
  input  logic                              s_wready,
  input  logic [1:0]                        s_bresp,
  input  logic                              s_bvalid,
  output logic                              s_bready,
  output logic                              grant_valid,
  output logic [IDW-1:0]                    grant_id
);

  localparam logic [2:0] IDLE = 3'd0, RD_A = 3'd1, RD_D = 3'd2, WR = 3'd3, WR_B = 3'd4;

  logic [2:0]             state_q, state_d;
  logic [IDW-1:0]         rr_ptr_q, rr_ptr_d, gid_q, gid_d, win;
  logic                   gvld_q, gvld_d, aw_done_q, aw_done_d, w_done_q, w_done_d, found;
  logic [NUM_MASTERS-1:0] req;
  int                     idx, gi;

  // First requester at or after rr_ptr, wrapping around.
  always_comb begin
    req   = m_arvalid | m_awvalid;
    win   = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < NUM_MASTERS; k++) begin
      idx = int'(rr_ptr_q) + k;
      if (idx >= NUM_MASTERS) idx = idx - NUM_MASTERS;
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = IDW'(idx);
      end
    end
  end

  always_comb begin
    gi        = int'(gid_q);
    s_araddr  = m_araddr[gi*ADDR_WIDTH +: ADDR_WIDTH];
    s_awaddr  = m_awaddr[gi*ADDR_WIDTH +: ADDR_WIDTH];
    s_wdata   = m_wdata[gi*DATA_WIDTH +: DATA_WIDTH];
    s_wstrb   = m_wstrb[gi*STRB_WIDTH +: STRB_WIDTH];
    m_rdata   = s_rdata;
    m_rresp   = s_rresp;
    m_bresp   = s_bresp;
    s_arvalid = (state_q == RD_A) && m_arvalid[gi];
    s_rready  = (state_q == RD_D) && m_rready[gi];
    // Each write channel is masked off once its own handshake has completed.
    s_awvalid = (state_q == WR) && !aw_done_q && m_awvalid[gi];
    s_wvalid  = (state_q == WR) && !w_done_q && m_wvalid[gi];
    s_bready  = (state_q == WR_B) && m_bready[gi];
    m_arready = '0;
    m_rvalid  = '0;
    m_awready = '0;
    m_wready  = '0;
    m_bvalid  = '0;
    m_arready[gi] = (state_q == RD_A) && s_arready;
    m_rvalid[gi]  = (state_q == RD_D) && s_rvalid;
    m_awready[gi] = (state_q == WR) && !aw_done_q && s_awready;
    m_wready[gi]  = (state_q == WR) && !w_done_q && s_wready;
    m_bvalid[gi]  = (state_q == WR_B) && s_bvalid;
  end

  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    gid_d     = gid_q;
    gvld_d    = gvld_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    case (state_q)
      IDLE: if (found) begin
        gid_d    = win;
        gvld_d   = 1'b1;
        rr_ptr_d = (int'(win) == NUM_MASTERS-1) ? '0 : win + IDW'(1);
        state_d  = m_arvalid[win] ? RD_A : WR;
      end
      RD_A: if (s_arvalid && s_arready) state_d = RD_D;
      RD_D: if (s_rvalid && s_rready) begin
        state_d = IDLE;
        gvld_d  = 1'b0;
      end
      WR: begin
        aw_done_d = aw_done_q | (s_awvalid & s_awready);
        w_done_d  = w_done_q | (s_wvalid & s_wready);
        if (aw_done_d && w_done_d) begin
          state_d   = WR_B;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
        end
      end
      WR_B: if (s_bvalid && s_bready) begin
        state_d = IDLE;
        gvld_d  = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      rr_ptr_q  <= '0;
      gid_q     <= '0;
      gvld_q    <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      gid_q     <= gid_d;
      gvld_q    <= gvld_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
    end
  end

  assign grant_valid = gvld_q;
  assign grant_id    = gid_q;

endmodule

// File: tb/tb_axi_lite_arbiter.sv
// Directed bench for axi_lite_arbiter with three masters; the bench plays both masters and slave.
module tb_axi_lite_arbiter;
  localparam int NM = 3, AW = 32, DW = 32, SW = 4, IDW = 2;

  logic clk = 1'b0, rst_n;
  logic [NM*AW-1:0] m_araddr, m_awaddr;
  logic [NM*DW-1:0] m_wdata;
  logic [NM*SW-1:0] m_wstrb;
  logic [NM-1:0] m_arvalid, m_arready, m_rvalid, m_rready, m_awvalid, m_awready;
  logic [NM-1:0] m_wvalid, m_wready, m_bvalid, m_bready;
  logic [DW-1:0] m_rdata, s_rdata, s_wdata;
  logic [1:0] m_rresp, m_bresp, s_rresp, s_bresp;
  logic [AW-1:0] s_araddr, s_awaddr;
  logic [SW-1:0] s_wstrb;
  logic s_arvalid, s_arready, s_rvalid, s_rready, s_awvalid, s_awready;
  logic s_wvalid, s_wready, s_bvalid, s_bready, grant_valid;
  logic [IDW-1:0] grant_id;
  int checks = 0, errors = 0;

  axi_lite_arbiter #(.NUM_MASTERS(NM), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .m_araddr(m_araddr), .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready),
    .m_awaddr(m_awaddr), .m_awvalid(m_awvalid), .m_awready(m_awready),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
    .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
    .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
    .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
    .grant_valid(grant_valid), .grant_id(grant_id)
  );

  always #5 clk = ~clk;

  task automatic clear_inputs();
    m_arvalid = '0; m_awvalid = '0; m_wvalid = '0; m_rready = '0; m_bready = '0;
    s_arready = 0; s_rvalid = 0; s_awready = 0; s_wready = 0; s_bvalid = 0;
    s_rdata = '0; s_rresp = '0; s_bresp = '0;
  endtask

  task automatic reset_dut();
    @(negedge clk);
    rst_n = 1'b0;
    clear_inputs();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Starts and ends on a negedge with the DUT in IDLE and requests already driven.
  task automatic serve_read(input int g, input logic [31:0] d, input logic [1:0] rs);
    logic [NM-1:0] oh;
    logic [31:0] ea;
    oh = 3'b001 << g;
    ea = 32'h8000_0000 + 32'(g) * 32'h100;
    #1;
    checks++; if (grant_valid !== 1'b0 || s_arvalid !== 1'b0) begin errors++; $display("FAIL rd_idle: gv=%b arv=%b exp 0 0", grant_valid, s_arvalid); end
    @(negedge clk); s_arready = 1; #1;
    checks++; if (grant_valid !== 1'b1 || grant_id !== IDW'(g)) begin errors++; $display("FAIL rd_grant: gv=%b id=%0d exp 1 %0d", grant_valid, grant_id, g); end
    checks++; if (s_arvalid !== 1'b1 || s_araddr !== ea) begin errors++; $display("FAIL rd_ar: v=%b a=%h exp 1 %h", s_arvalid, s_araddr, ea); end
    checks++; if (m_arready !== oh) begin errors++; $display("FAIL rd_arready: %b exp %b", m_arready, oh); end
    @(negedge clk); s_arready = 0; s_rvalid = 1; s_rdata = d; s_rresp = rs; m_rready = oh; #1;
    checks++; if (m_rvalid !== oh || s_rready !== 1'b1 || s_arvalid !== 1'b0) begin errors++; $display("FAIL rd_r: rv=%b rr=%b arv=%b exp %b 1 0", m_rvalid, s_rready, s_arvalid, oh); end
    checks++; if (m_rdata !== d || m_rresp !== rs) begin errors++; $display("FAIL rd_data: %h/%0d exp %h/%0d", m_rdata, m_rresp, d, rs); end
    @(negedge clk); s_rvalid = 0; m_rready = '0;
  endtask

  task automatic serve_write(input int g, input logic [31:0] d, input logic [3:0] st);
    logic [NM-1:0] oh;
    logic [31:0] ea;
    oh = 3'b001 << g;
    ea = 32'h4000_0000 + 32'(g) * 32'h100;
    #1;
    checks++; if (grant_valid !== 1'b0 || s_awvalid !== 1'b0) begin errors++; $display("FAIL wr_idle: gv=%b awv=%b exp 0 0", grant_valid, s_awvalid); end
    @(negedge clk); s_awready = 1; s_wready = 1; #1;
    checks++; if (grant_id !== IDW'(g) || s_awvalid !== 1'b1 || s_wvalid !== 1'b1) begin errors++; $display("FAIL wr_fwd: id=%0d awv=%b wv=%b exp %0d 1 1", grant_id, s_awvalid, s_wvalid, g); end
    checks++; if (s_awaddr !== ea || s_wdata !== d || s_wstrb !== st) begin errors++; $display("FAIL wr_payload: %h %h %h exp %h %h %h", s_awaddr, s_wdata, s_wstrb, ea, d, st); end
    checks++; if (m_awready !== oh || m_wready !== oh || s_arvalid !== 1'b0) begin errors++; $display("FAIL wr_ready: %b %b arv=%b exp %b", m_awready, m_wready, s_arvalid, oh); end
    @(negedge clk); s_awready = 0; s_wready = 0; m_awvalid[g] = 0; m_wvalid[g] = 0;
    s_bvalid = 1; s_bresp = 2'b00; m_bready = oh; #1;
    checks++; if (m_bvalid !== oh || s_bready !== 1'b1) begin errors++; $display("FAIL wr_b: bv=%b br=%b exp %b 1", m_bvalid, s_bready, oh); end
    @(negedge clk); s_bvalid = 0; m_bready = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    clear_inputs();
    m_arvalid = 3'b111;
    #12;
    checks++; if (grant_valid !== 1'b0 || grant_id !== '0) begin errors++; $display("FAIL reset_grant: gv=%b id=%0d exp 0 0", grant_valid, grant_id); end
    checks++; if ({s_arvalid, s_awvalid, s_wvalid, s_rready, s_bready} !== 5'b0) begin errors++; $display("FAIL reset_svalid: %b exp 0", {s_arvalid, s_awvalid, s_wvalid, s_rready, s_bready}); end
    checks++; if ({m_arready, m_awready, m_wready, m_rvalid, m_bvalid} !== 15'b0) begin errors++; $display("FAIL reset_mready: %b exp 0", {m_arready, m_awready, m_wready, m_rvalid, m_bvalid}); end
    m_arvalid = '0;
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_single_read();
    @(negedge clk); m_arvalid[0] = 1;
    serve_read(0, 32'hDEAD_BEEF, 2'b00);
    m_arvalid[0] = 0; #1;
    checks++; if (grant_valid !== 1'b0 || m_rvalid !== '0) begin errors++; $display("FAIL single_done: gv=%b rv=%b exp 0 0", grant_valid, m_rvalid); end
  endtask

  task automatic test_contention();
    reset_dut();
    m_arvalid = 3'b011;
    serve_read(0, 32'h0000_1000, 2'b00);
    serve_read(1, 32'h0000_1001, 2'b01);
    serve_read(0, 32'h0000_1002, 2'b00);
    serve_read(1, 32'h0000_1003, 2'b00);
    m_arvalid = '0;
  endtask

  task automatic test_write_w_first();
    m_wvalid[1] = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (grant_valid !== 1'b0 || s_wvalid !== 1'b0 || m_wready !== '0) begin errors++; $display("FAIL wfirst_wait: gv=%b wv=%b wr=%b exp 0 0 0", grant_valid, s_wvalid, m_wready); end
      @(negedge clk);
    end
    m_awvalid[1] = 1; #1;
    checks++; if (grant_valid !== 1'b0) begin errors++; $display("FAIL wfirst_lat: gv=%b exp 0", grant_valid); end
    @(negedge clk); s_wready = 1; #1;
    checks++; if (grant_id !== 2'd1 || s_wvalid !== 1'b1 || s_wdata !== 32'h1234_5678 || s_wstrb !== 4'hF) begin errors++; $display("FAIL wfirst_w: id=%0d wv=%b %h %h", grant_id, s_wvalid, s_wdata, s_wstrb); end
    checks++; if (m_wready !== 3'b010 || m_awready !== '0 || s_awvalid !== 1'b1) begin errors++; $display("FAIL wfirst_rdy: wr=%b awr=%b awv=%b exp 010 000 1", m_wready, m_awready, s_awvalid); end
    @(negedge clk); s_wready = 1; s_awready = 1; #1;
    checks++; if (s_wvalid !== 1'b0 || m_wready !== '0 || m_awready !== 3'b010 || m_bvalid !== '0) begin errors++; $display("FAIL wfirst_mask: wv=%b wr=%b awr=%b bv=%b", s_wvalid, m_wready, m_awready, m_bvalid); end
    @(negedge clk); s_wready = 0; s_awready = 0; #1;
    checks++; if (s_awvalid !== 1'b0 || s_wvalid !== 1'b0 || grant_valid !== 1'b1 || m_bvalid !== '0) begin errors++; $display("FAIL wfirst_wb: awv=%b wv=%b gv=%b bv=%b", s_awvalid, s_wvalid, grant_valid, m_bvalid); end
    m_awvalid[1] = 0; m_wvalid[1] = 0; s_bvalid = 1; m_bready = 3'b010; #1;
    checks++; if (m_bvalid !== 3'b010 || s_bready !== 1'b1) begin errors++; $display("FAIL wfirst_b: bv=%b br=%b exp 010 1", m_bvalid, s_bready); end
    @(negedge clk); s_bvalid = 0; m_bready = '0; #1;
    checks++; if (grant_valid !== 1'b0) begin errors++; $display("FAIL wfirst_done: gv=%b exp 0", grant_valid); end
  endtask

  task automatic test_round_robin_wrap();
    reset_dut();
    m_arvalid[0] = 1; m_awvalid[0] = 1; m_wvalid[0] = 1; m_arvalid[2] = 1;
    serve_read(0, 32'hAAAA_0000, 2'b00);
    m_arvalid[0] = 0;
    serve_read(2, 32'hAAAA_0002, 2'b10);
    m_arvalid[2] = 0;
    serve_write(0, 32'h0BAD_F00D, 4'h3);
  endtask

  task automatic test_backpressure();
    m_arvalid = 3'b011;
    @(negedge clk); s_arready = 1;
    @(negedge clk); s_arready = 0; m_rready = 3'b010;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++; if (grant_id !== 2'd1 || grant_valid !== 1'b1 || m_rvalid !== '0 || s_rready !== 1'b1 || s_arvalid !== 1'b0) begin errors++; $display("FAIL bp_r_hold%0d: id=%0d gv=%b rv=%b rr=%b arv=%b", i, grant_id, grant_valid, m_rvalid, s_rready, s_arvalid); end
      @(negedge clk);
    end
    s_rvalid = 1; s_rdata = 32'hCAFE_F00D; s_rresp = 2'b11; #1;
    checks++; if (m_rvalid !== 3'b010 || m_rdata !== 32'hCAFE_F00D || m_rresp !== 2'b11) begin errors++; $display("FAIL bp_r_fire: rv=%b %h %0d", m_rvalid, m_rdata, m_rresp); end
    @(negedge clk); s_rvalid = 0; m_rready = '0; m_arvalid = '0;
    m_awvalid[2] = 1; m_wvalid[2] = 1;
    @(negedge clk); s_awready = 1; s_wready = 1;
    @(negedge clk); s_awready = 0; s_wready = 0; m_awvalid[2] = 0; m_wvalid[2] = 0;
    s_bvalid = 1; s_bresp = 2'b10;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++; if (grant_id !== 2'd2 || m_bvalid !== 3'b100 || m_bresp !== 2'b10 || s_bready !== 1'b0) begin errors++; $display("FAIL bp_b_hold%0d: id=%0d bv=%b resp=%0d br=%b", i, grant_id, m_bvalid, m_bresp, s_bready); end
      @(negedge clk);
    end
    m_bready = 3'b100; #1;
    checks++; if (s_bready !== 1'b1 || m_bvalid !== 3'b100) begin errors++; $display("FAIL bp_b_fire: br=%b bv=%b", s_bready, m_bvalid); end
    @(negedge clk); s_bvalid = 0; m_bready = '0; #1;
    checks++; if (grant_valid !== 1'b0) begin errors++; $display("FAIL bp_done: gv=%b exp 0", grant_valid); end
  endtask

  task automatic test_reset_in_wrb();
    m_awvalid[1] = 1; m_wvalid[1] = 1;
    @(negedge clk); s_awready = 1; s_wready = 1;
    @(negedge clk); s_awready = 0; s_wready = 0; m_awvalid[1] = 0; m_wvalid[1] = 0;
    s_bvalid = 1; m_bready = 3'b010; #1;
    checks++; if (m_bvalid !== 3'b010 || grant_id !== 2'd1) begin errors++; $display("FAIL rstwb_pre: bv=%b id=%0d", m_bvalid, grant_id); end
    #1 rst_n = 1'b0; #1;
    checks++; if (grant_valid !== 1'b0 || m_bvalid !== '0 || s_bready !== 1'b0 || grant_id !== '0) begin errors++; $display("FAIL rstwb_async: gv=%b bv=%b br=%b id=%0d", grant_valid, m_bvalid, s_bready, grant_id); end
    clear_inputs();
    @(negedge clk); rst_n = 1'b1;
    m_arvalid = 3'b101;
    serve_read(0, 32'h5555_0000, 2'b00);
    m_arvalid[0] = 0;
    serve_read(2, 32'h5555_0002, 2'b00);
    m_arvalid = '0;
  endtask

  initial begin
    for (int i = 0; i < NM; i++) begin
      m_araddr[i*AW +: AW] = 32'h8000_0000 + 32'(i) * 32'h100;
      m_awaddr[i*AW +: AW] = 32'h4000_0000 + 32'(i) * 32'h100;
    end
    m_wdata = '0; m_wstrb = '0;
    m_wdata[0*DW +: DW] = 32'h0BAD_F00D; m_wstrb[0*SW +: SW] = 4'h3;
    m_wdata[1*DW +: DW] = 32'h1234_5678; m_wstrb[1*SW +: SW] = 4'hF;
    m_wdata[2*DW +: DW] = 32'h7777_2222; m_wstrb[2*SW +: SW] = 4'hC;
    test_reset();
    test_single_read();
    test_contention();
    test_write_w_first();
    test_round_robin_wrap();
    test_backpressure();
    test_reset_in_wrb();
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
